// File: rtl/freq_meter_if.sv
// Signal bundle for freq_meter: measured input, control and results.
interface freq_meter_if;
  logic        sig_in;
  logic        enable;
  logic        conf_to;
  logic [31:0] Din;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        timeout;
  logic        busy;

  modport master (
    output sig_in, enable, conf_to, Din,
    input  period, high_time, valid, timeout, busy
  );

  modport slave (
    input  sig_in, enable, conf_to, Din,
    output period, high_time, valid, timeout, busy
  );
endinterface

// File: rtl/freq_meter.sv
// Period / high-time meter for an asynchronous input, with timeout.
// Optional FREQ_METER_AVG_EN: report the mean of 4 measurements.
module freq_meter #(
  parameter logic [31:0] TO_DEFAULT = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  freq_meter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] per_q, per_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] to_q, to_d;
  logic        valid_q, valid_d;
  logic        tout_q, tout_d;
  logic        rise, hit;
  logic [31:0] cnt_inc, hcnt_inc;

`ifdef FREQ_METER_AVG_EN
  logic [33:0] accp_q, accp_d;
  logic [33:0] acch_q, acch_d;
  logic [1:0]  idx_q, idx_d;
  logic [33:0] sump, sumh;
  assign sump = accp_q + {2'b00, cnt_q};
  assign sumh = acch_q + {2'b00, hcnt_q};
`endif

  assign rise     = s2_q & ~s3_q;
  assign hit      = (to_q != '0) && (cnt_q >= to_q);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign hcnt_inc = (s2_q && !(&hcnt_q)) ? hcnt_q + 32'd1 : hcnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    per_d   = per_q;
    hi_d    = hi_q;
    valid_d = 1'b0;
    tout_d  = tout_q;
    to_d    = bus.conf_to ? bus.Din : to_q;
`ifdef FREQ_METER_AVG_EN
    accp_d  = accp_q;
    acch_d  = acch_q;
    idx_d   = idx_q;
`endif
    if (!bus.enable) begin
      state_d = IDLE;
`ifdef FREQ_METER_AVG_EN
      accp_d = '0;
      acch_d = '0;
      idx_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = 32'd1;
            hcnt_d  = 32'd1;
          end else if (hit) begin
            tout_d = 1'b1;
            cnt_d  = '0;
            hcnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt_d  = 32'd1;
            hcnt_d = 32'd1;
            tout_d = 1'b0;
`ifdef FREQ_METER_AVG_EN
            if (idx_q == 2'd3) begin
              per_d   = sump[33:2];
              hi_d    = sumh[33:2];
              valid_d = 1'b1;
              accp_d  = '0;
              acch_d  = '0;
              idx_d   = '0;
            end else begin
              accp_d = sump;
              acch_d = sumh;
              idx_d  = idx_q + 2'd1;
            end
`else
            per_d   = cnt_q;
            hi_d    = hcnt_q;
            valid_d = 1'b1;
`endif
          end else if (hit) begin
            // Lost the signal: re-arm and keep last results
            tout_d  = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
            hcnt_d  = '0;
`ifdef FREQ_METER_AVG_EN
            accp_d = '0;
            acch_d = '0;
            idx_d  = '0;
`endif
          end else begin
            cnt_d  = cnt_inc;
            hcnt_d = hcnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      to_q    <= TO_DEFAULT;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      accp_q  <= '0;
      acch_q  <= '0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s1_q    <= bus.sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
`ifdef FREQ_METER_AVG_EN
      accp_q  <= accp_d;
      acch_q  <= acch_d;
      idx_q   <= idx_d;
`endif
    end
  end

  assign bus.period    = per_q;
  assign bus.high_time = hi_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = tout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
